// File: rtl/mdu_sequencer.sv
// mdu_sequencer
// Multi-cycle unsigned MULTU/DIVU sequencer. It borrows the shared 32-bit
// add/subtract ALU for 32 iterations and leaves its results in HI/LO.
// Only one operation is in flight at a time.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   start, op            request (sampled only in IDLE); op 0=MULTU, 1=DIVU
//   rs_val, rt_val       multiplicand/dividend, multiplier/divisor
//   alu_a/alu_b/alu_ctl  drive to the shared ALU (ctl 00 add, 01 sub)
//   alu_out, alu_c       ALU result and carry/borrow, same cycle
//   busy, done, err      in RUN; one-cycle completion pulse; error flag
//   hi, lo               result registers
//
// Build option: define MDU_DIV_EN to include the restoring divider. Without
// it, a DIVU request completes next cycle with err=1 and hi/lo untouched.
module mdu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [1:0]  alu_ctl,
  input  logic [31:0] alu_out,
  input  logic        alu_c,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] m;
  logic [4:0]  cnt;

`ifdef MDU_DIV_EN
  logic        op_q;
  logic [31:0] rem_sh;
  // Partial remainder shifted left with the next dividend bit pulled in.
  assign rem_sh = {hi[30:0], lo[31]};
`endif

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) begin
`ifdef MDU_DIV_EN
        state_nxt = (op && (rt_val == 32'd0)) ? DONE : RUN;
`else
        state_nxt = op ? DONE : RUN;
`endif
      end
      RUN:     if (cnt == 5'd31) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ALU operands are only driven while iterating; idle drive is all zero.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_ctl = 2'b00;
    if (state == RUN) begin
`ifdef MDU_DIV_EN
      if (op_q) begin
        alu_ctl = 2'b01;
        alu_a   = rem_sh;
        alu_b   = m;
      end else begin
        alu_a = hi;
        alu_b = lo[0] ? m : '0;
      end
`else
      alu_a = hi;
      alu_b = lo[0] ? m : '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi  <= '0;
      lo  <= '0;
      m   <= '0;
      cnt <= '0;
      err <= 1'b0;
`ifdef MDU_DIV_EN
      op_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          m   <= rt_val;
          cnt <= '0;
          err <= 1'b0;
          if (!op) begin
            hi <= '0;
            lo <= rs_val;
`ifdef MDU_DIV_EN
            op_q <= 1'b0;
`endif
          end else begin
`ifdef MDU_DIV_EN
            op_q <= 1'b1;
            if (rt_val == 32'd0) begin
              hi  <= rs_val;
              lo  <= 32'hFFFF_FFFF;
              err <= 1'b1;
            end else begin
              hi <= '0;
              lo <= rs_val;
            end
`else
            err <= 1'b1;
`endif
          end
        end
        RUN: begin
          cnt <= cnt + 5'd1;
`ifdef MDU_DIV_EN
          if (op_q) begin
            // hi[31] set means the shifted remainder overflowed 32 bits,
            // so it is certainly >= M even though the ALU saw a borrow.
            if (hi[31] || !alu_c) begin
              hi <= alu_out;
              lo <= {lo[30:0], 1'b1};
            end else begin
              hi <= rem_sh;
              lo <= {lo[30:0], 1'b0};
            end
          end else begin
            hi <= {alu_c, alu_out[31:1]};
            lo <= {alu_out[0], lo[31:1]};
          end
`else
          // Shift-add: carry becomes the new top bit of the product.
          hi <= {alu_c, alu_out[31:1]};
          lo <= {alu_out[0], lo[31:1]};
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, op;
  logic [31:0] rs_val, rt_val;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [1:0]  alu_ctl;
  logic        alu_c;
  logic        busy, done, err;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mdu_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl),
    .alu_out(alu_out), .alu_c(alu_c),
    .busy(busy), .done(done), .err(err), .hi(hi), .lo(lo)
  );

  // Shared ALU: add gives carry-out, subtract gives borrow (A < B).
  always_comb begin
    logic [32:0] sum;
    sum = {1'b0, alu_a} + {1'b0, alu_b};
    if (alu_ctl == 2'b01) begin
      alu_out = alu_a - alu_b;
      alu_c   = (alu_a < alu_b);
    end else begin
      alu_out = sum[31:0];
      alu_c   = sum[32];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        op;
    logic [31:0] rs, rt, hi, lo;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[10];
  int   nvec;

  // Issues one request and waits (bounded) for done. Returns latency in
  // cycles after the accepting edge and the number of busy cycles seen.
  task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_n);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; busy_n = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) busy_n++;
    end while (!done && lat < 100);
  endtask

  initial begin
    int lat, busy_n, dn;
    logic [31:0] hold_hi, hold_lo;

    vecs[0] = '{1'b0, 32'd7,          32'd6,          32'd0,          32'd42,         1'b0, 33};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'h0000_0001,  1'b0, 33};
    vecs[2] = '{1'b0, 32'h1234_5678,  32'h10,         32'h1,          32'h2345_6780,  1'b0, 33};
    vecs[3] = '{1'b0, 32'h8000_0000,  32'd2,          32'h1,          32'h0,          1'b0, 33};
`ifdef MDU_DIV_EN
    vecs[4] = '{1'b1, 32'd100,        32'd7,          32'd2,          32'd14,         1'b0, 33};
    vecs[5] = '{1'b1, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  32'd1,          1'b0, 33};
    vecs[6] = '{1'b1, 32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF,  1'b1, 1};
    vecs[7] = '{1'b0, 32'd0,          32'hDEAD_BEEF,  32'd0,          32'd0,          1'b0, 33};
    vecs[8] = '{1'b0, 32'h0000_FFFF,  32'h0001_0001,  32'd0,          32'hFFFF_FFFF,  1'b0, 33};
    vecs[9] = '{1'b1, 32'h1234_5678,  32'd1,          32'd0,          32'h1234_5678,  1'b0, 33};
    nvec = 10;
`else
    // Divider absent: hi/lo keep the previous product (hi=1, lo=0).
    vecs[4] = '{1'b1, 32'd100,        32'd7,          32'h1,          32'h0,          1'b1, 1};
    vecs[5] = '{1'b1, 32'd5,          32'd0,          32'h1,          32'h0,          1'b1, 1};
    vecs[6] = '{1'b0, 32'd0,          32'hDEAD_BEEF,  32'd0,          32'd0,          1'b0, 33};
    vecs[7] = '{1'b0, 32'h0000_FFFF,  32'h0001_0001,  32'd0,          32'hFFFF_FFFF,  1'b0, 33};
    nvec = 8;
`endif

    rst = 1'b1; start = 1'b0; op = 1'b0; rs_val = '0; rt_val = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_flags", {busy, done, err}, 0);
    check("reset_alu", {alu_a, alu_b, alu_ctl}, 0);

    for (int i = 0; i < nvec; i++) begin
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, lat, busy_n);
      $display("vec %0d op=%0d rs=%0h rt=%0h", i, vecs[i].op, vecs[i].rs, vecs[i].rt);
      check("latency", lat, vecs[i].lat);
      check("busy_cycles", busy_n, (vecs[i].lat == 33) ? 32 : 0);
      check("hi", hi, vecs[i].hi);
      check("lo", lo, vecs[i].lo);
      check("err", err, vecs[i].err);
      @(negedge clk);
      check("done_width", done, 0);
      check("idle_alu", {alu_a, alu_b, alu_ctl}, 0);
    end

    // start during RUN must be ignored; exactly one done, original result.
    @(negedge clk);
    start = 1'b1; op = 1'b0; rs_val = 32'd7; rt_val = 32'd6;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; op = 1'b0; rs_val = 32'd9; rt_val = 32'd9;
    @(negedge clk);
    start = 1'b0;
    dn = 0; hold_hi = '1; hold_lo = '1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) begin
        dn++;
        hold_hi = hi;
        hold_lo = lo;
      end
    end
    check("ignore_start_dones", dn, 1);
    check("ignore_start_hi", hold_hi, 0);
    check("ignore_start_lo", hold_lo, 42);

    // Reset in the middle of an operation aborts it with no done.
    @(negedge clk);
    start = 1'b1; op = 1'b0; rs_val = 32'hFFFF_FFFF; rt_val = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    check("midrun_busy", busy, 1);
    check("midrun_ctl", alu_ctl, 2'b00);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_hilo", {hi, lo}, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("abort_no_done", dn, 0);
    run_op(1'b0, 32'd3, 32'd4, lat, busy_n);
    check("after_abort_lat", lat, 33);
    check("after_abort_hi", hi, 0);
    check("after_abort_lo", lo, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
